// File: rtl/apb_master_if.sv
// Bundle of the command/response handshake and APB3 bus seen by apb_master.
// The master modport is the bridge's view; slave is the surrounding environment.
interface apb_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_timeout;

  logic [ADDR_WIDTH-1:0] PADDR;
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    input  PRDATA, PREADY, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    output PRDATA, PREADY, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA
  );
endinterface

// File: rtl/apb_master.sv
// Single-outstanding APB3 requester: turns one valid/ready command into a
// SETUP/ACCESS transfer and returns a registered response, with optional timeout.
module apb_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic          PCLK,
  input logic          PRESETn,
  apb_master_if.master bus
);

  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
  localparam int CNT_W      = TIMEOUT_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = TIMEOUT_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e                state_q,       state_d;
  logic [CNT_W-1:0]      wait_cnt_q,    wait_cnt_d;
  logic                  cmd_ready_q,   cmd_ready_d;
  logic                  rsp_valid_q,   rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q,   rsp_rdata_d;
  logic                  rsp_err_q,     rsp_err_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic [ADDR_WIDTH-1:0] paddr_q,       paddr_d;
  logic                  psel_q,        psel_d;
  logic                  penable_q,     penable_d;
  logic                  pwrite_q,      pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_q,      pwdata_d;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q       <= IDLE;
      wait_cnt_q    <= '0;
      cmd_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      paddr_q       <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      paddr_q       <= paddr_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
    end
  end

  // Every output is a flop, so each branch sets the value the bus shows next cycle.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    cmd_ready_d   = cmd_ready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    paddr_d       = paddr_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          state_d     = SETUP;
          cmd_ready_d = 1'b0;
          wait_cnt_d  = '0;
          paddr_d     = bus.cmd_addr;
          pwrite_d    = bus.cmd_write;
          pwdata_d    = bus.cmd_write ? bus.cmd_wdata : '0;
          psel_d      = 1'b1;
          penable_d   = 1'b0;
        end
      end

      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end

      ACCESS: begin
        if (bus.PREADY) begin
          state_d       = RESP;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = pwrite_q ? '0 : bus.PRDATA;
          rsp_err_d     = bus.PSLVERR;
          rsp_timeout_d = 1'b0;
        end else if (TIMEOUT_EN && (wait_cnt_q == CNT_LAST)) begin
          // This wait cycle brings the count to TIMEOUT_CYCLES: abandon the transfer.
          state_d       = RESP;
          wait_cnt_d    = wait_cnt_q + 1'b1;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
        end else if (wait_cnt_q != CNT_MAX) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      RESP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.PADDR       = paddr_q;
  assign bus.PSEL        = psel_q;
  assign bus.PENABLE     = penable_q;
  assign bus.PWRITE      = pwrite_q;
  assign bus.PWDATA      = pwdata_q;

`ifndef SYNTHESIS
  a_penable_needs_psel: assert property (@(posedge PCLK) disable iff (!PRESETn)
    penable_q |-> psel_q);

  a_access_stable: assert property (@(posedge PCLK) disable iff (!PRESETn)
    (state_q == ACCESS) |-> ($stable(paddr_q) && $stable(pwrite_q) && $stable(pwdata_q)));

  a_ready_only_idle: assert property (@(posedge PCLK) disable iff (!PRESETn)
    cmd_ready_q |-> (state_q == IDLE));
`endif

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: directed vector table, hand sequences for reset,
// then random transfers checked against a latency/response formula model.
module tb_apb_master;

  localparam int AW          = 32;
  localparam int DW          = 32;
  localparam int TO          = 4;
  localparam int CYCLE_LIMIT = 40;

  logic pclk    = 1'b0;
  logic presetn = 1'b0;

  always #5 pclk = ~pclk;

  apb_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  apb_master #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .PCLK   (pclk),
    .PRESETn(presetn),
    .bus    (bus.master)
  );

  typedef struct {
    bit            write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            waits;
    bit            slverr;
    logic [DW-1:0] rdata;
    int            rdy_delay;
    int            exp_lat;
    logic [DW-1:0] exp_rdata;
    bit            exp_err;
    bit            exp_to;
  } vec_t;

  typedef struct {
    int            lat;
    logic [DW-1:0] rdata;
    bit            err;
    bit            to;
    int            setup_cnt;
    int            access_cnt;
    bit            accept_ok;
    bit            busy_ok;
    bit            apb_ok;
    bit            hold_ok;
    bit            idle_ok;
  } obs_t;

  int vectors     = 0;
  int miscompares = 0;

  vec_t vec_tbl[$];

  function automatic vec_t mkVec(bit w, logic [AW-1:0] a, logic [DW-1:0] d, int waits,
                                 bit se, logic [DW-1:0] rd, int dly,
                                 int lat, logic [DW-1:0] erd, bit eerr, bit eto);
    vec_t v;
    v.write = w;  v.addr = a;  v.wdata = d;  v.waits = waits;
    v.slverr = se; v.rdata = rd; v.rdy_delay = dly;
    v.exp_lat = lat; v.exp_rdata = erd; v.exp_err = eerr; v.exp_to = eto;
    return v;
  endfunction

  // Expected response from the transfer rules: fixed 3-cycle base plus waits, capped by the timeout.
  function automatic vec_t refModel(vec_t v);
    vec_t r = v;
    bit timed_out = (TO != 0) && (v.waits >= TO);
    r.exp_lat   = timed_out ? (2 + TO) : (3 + v.waits);
    r.exp_err   = timed_out || v.slverr;
    r.exp_to    = timed_out;
    r.exp_rdata = (timed_out || v.write) ? '0 : v.rdata;
    return r;
  endfunction

  task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge pclk);
    #1;
  endtask

  task automatic pulseReset();
    @(negedge pclk);
    presetn = 1'b0;
    @(negedge pclk);
    @(negedge pclk);
    presetn = 1'b1;
    stepCycle();
  endtask

  // Presents one command in the current (IDLE) cycle and acts as the completer until the response is consumed.
  task automatic applyStimulus(input vec_t v, output obs_t o);
    int acc;
    bit done;
    o.lat = -1; o.rdata = '0; o.err = 1'b0; o.to = 1'b0;
    o.setup_cnt = 0; o.access_cnt = 0;
    o.busy_ok = 1'b1; o.apb_ok = 1'b1; o.hold_ok = 1'b1; o.idle_ok = 1'b0;
    o.accept_ok = (bus.cmd_ready === 1'b1);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = v.write;
    bus.cmd_addr  = v.addr;
    bus.cmd_wdata = v.wdata;
    bus.rsp_ready = 1'b0;
    acc  = 0;
    done = 1'b0;
    for (int cyc = 1; cyc <= CYCLE_LIMIT && !done; cyc++) begin
      stepCycle();
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'($urandom);
      bus.cmd_addr  = $urandom;
      bus.cmd_wdata = $urandom;
      bus.PREADY    = 1'($urandom);
      bus.PSLVERR   = 1'($urandom);
      bus.PRDATA    = $urandom;
      if (bus.rsp_valid === 1'b1) begin
        o.lat = cyc;
        done  = 1'b1;
        if (bus.PSEL !== 1'b0 || bus.PENABLE !== 1'b0) o.apb_ok = 1'b0;
      end else begin
        if (bus.cmd_ready !== 1'b0) o.busy_ok = 1'b0;
        if (bus.PSEL === 1'b1) begin
          if (bus.PADDR !== v.addr || bus.PWRITE !== v.write ||
              bus.PWDATA !== (v.write ? v.wdata : '0)) o.apb_ok = 1'b0;
          if (bus.PENABLE === 1'b1) begin
            bus.PREADY = (acc >= v.waits);
            if (acc >= v.waits) begin
              bus.PRDATA  = v.rdata;
              bus.PSLVERR = v.slverr;
            end
            acc++;
          end else begin
            o.setup_cnt++;
          end
        end else if (bus.PENABLE !== 1'b0) begin
          o.apb_ok = 1'b0;
        end
      end
    end
    o.access_cnt = acc;

    if (done) begin
      o.rdata = bus.rsp_rdata;
      o.err   = bus.rsp_err;
      o.to    = bus.rsp_timeout;
      for (int h = 0; h < v.rdy_delay; h++) begin
        bus.rsp_ready = 1'b0;
        bus.cmd_valid = 1'b1;
        stepCycle();
        if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== o.rdata || bus.rsp_err !== o.err ||
            bus.rsp_timeout !== o.to || bus.cmd_ready !== 1'b0 ||
            bus.PSEL !== 1'b0 || bus.PENABLE !== 1'b0) o.hold_ok = 1'b0;
      end
      bus.rsp_ready = 1'b1;
      bus.cmd_valid = 1'b1;
      stepCycle();
      o.idle_ok = (bus.cmd_ready === 1'b1) && (bus.rsp_valid === 1'b0) &&
                  (bus.PSEL === 1'b0) && (bus.PENABLE === 1'b0);
      bus.rsp_ready = 1'b0;
      bus.cmd_valid = 1'b0;
    end else begin
      bus.cmd_valid = 1'b0;
      pulseReset();
    end
  endtask

  task automatic checkOutput(input string tag, input vec_t v, input obs_t o);
    compare({tag, ".accept"},     o.accept_ok,  1);
    compare({tag, ".latency"},    o.lat,        v.exp_lat);
    compare({tag, ".setup_cyc"},  o.setup_cnt,  1);
    compare({tag, ".access_cyc"}, o.access_cnt, v.exp_lat - 2);
    compare({tag, ".busy"},       o.busy_ok,    1);
    compare({tag, ".apb"},        o.apb_ok,     1);
    compare({tag, ".rdata"},      o.rdata,      v.exp_rdata);
    compare({tag, ".err"},        o.err,        v.exp_err);
    compare({tag, ".timeout"},    o.to,         v.exp_to);
    compare({tag, ".hold"},       o.hold_ok,    1);
    compare({tag, ".idle"},       o.idle_ok,    1);
  endtask

  initial begin
    obs_t o;
    vec_t v;
    bit   seen;
    bit   ready_ok;

    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0; bus.PRDATA = '0; bus.PREADY = 1'b0; bus.PSLVERR = 1'b0;

    // Hand-derived expectations with TIMEOUT_CYCLES = 4.
    vec_tbl.push_back(mkVec(1, 32'h1000_0000, 32'h0000_0003, 0, 0, 32'hDEAD_BEEF, 0, 3, 32'h0, 0, 0));
    vec_tbl.push_back(mkVec(0, 32'h1000_0004, 32'hFFFF_FFFF, 3, 0, 32'h00D0_0005, 0, 6, 32'h00D0_0005, 0, 0));
    vec_tbl.push_back(mkVec(0, 32'h2000_0008, 32'h0, 0, 1, 32'h1234_5678, 1, 3, 32'h1234_5678, 1, 0));
    vec_tbl.push_back(mkVec(0, 32'h3000_000C, 32'h0, 10, 0, 32'hCAFE_F00D, 0, 6, 32'h0, 1, 1));
    vec_tbl.push_back(mkVec(1, 32'h4000_0010, 32'hA5A5_5A5A, 1, 0, 32'h5555_AAAA, 5, 4, 32'h0, 0, 0));
    vec_tbl.push_back(mkVec(1, 32'h5000_0014, 32'h0BAD_0BAD, 2, 1, 32'h7777_7777, 2, 5, 32'h0, 1, 0));
    vec_tbl.push_back(mkVec(1, 32'h6000_0018, 32'h1111_2222, 4, 0, 32'h3333_4444, 0, 6, 32'h0, 1, 1));
    vec_tbl.push_back(mkVec(0, 32'h7000_001C, 32'h0, 0, 0, 32'h8000_0001, 0, 3, 32'h8000_0001, 0, 0));

    repeat (3) @(posedge pclk);
    #1;
    compare("rst.cmd_ready",   bus.cmd_ready,   1);
    compare("rst.rsp_valid",   bus.rsp_valid,   0);
    compare("rst.rsp_rdata",   bus.rsp_rdata,   0);
    compare("rst.rsp_err",     bus.rsp_err,     0);
    compare("rst.rsp_timeout", bus.rsp_timeout, 0);
    compare("rst.psel",        bus.PSEL,        0);
    compare("rst.penable",     bus.PENABLE,     0);
    compare("rst.pwrite",      bus.PWRITE,      0);
    compare("rst.paddr",       bus.PADDR,       0);
    compare("rst.pwdata",      bus.PWDATA,      0);
    @(negedge pclk);
    presetn = 1'b1;
    stepCycle();
    compare("rst.release_ready", bus.cmd_ready, 1);

    foreach (vec_tbl[i]) begin
      applyStimulus(vec_tbl[i], o);
      checkOutput($sformatf("dir%0d", i), vec_tbl[i], o);
    end

    // Reset in the middle of ACCESS must kill the transfer without a response.
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 32'h5000_0020; bus.PREADY = 1'b0;
    stepCycle();
    bus.cmd_valid = 1'b0; bus.PREADY = 1'b0;
    stepCycle();
    compare("mid_rst.in_access", {bus.PSEL, bus.PENABLE}, 2'b11);
    #2 presetn = 1'b0;
    #1;
    compare("mid_rst.psel",    bus.PSEL,    0);
    compare("mid_rst.penable", bus.PENABLE, 0);
    @(negedge pclk);
    @(negedge pclk);
    presetn = 1'b1;
    bus.PREADY = 1'b1; bus.PRDATA = 32'h0BAD_CAFE;
    seen = 1'b0; ready_ok = 1'b1;
    for (int c = 0; c < 6; c++) begin
      stepCycle();
      if (bus.rsp_valid !== 1'b0) seen = 1'b1;
      if (bus.cmd_ready !== 1'b1) ready_ok = 1'b0;
    end
    compare("mid_rst.no_rsp",    seen,     0);
    compare("mid_rst.cmd_ready", ready_ok, 1);

    for (int n = 0; n < 40; n++) begin
      v.write     = 1'($urandom);
      v.addr      = $urandom;
      v.wdata     = $urandom;
      v.waits     = $urandom_range(0, 6);
      v.slverr    = 1'($urandom);
      v.rdata     = $urandom;
      v.rdy_delay = $urandom_range(0, 3);
      v = refModel(v);
      applyStimulus(v, o);
      checkOutput($sformatf("rnd%0d", n), v, o);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
